// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Central sequencer for the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM,
// MEM/WB) and the PC. Inserts load-use bubbles, flushes on redirects resolved
// in MEM, freezes the pipe while data memory is busy, traps memory timeouts
// and keeps saturating stall/flush performance counters.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   id_rs/id_rt  source register fields of the instruction in ID
//   ex_MemRead   instruction in EX is a load; ex_rt is its destination
//   mem_branch   branch in MEM; mem_zero is its ALU zero flag
//   mem_jump     jump in MEM
//   mem_access   instruction in MEM reads or writes data memory
//   dmem_ready   data memory completes its access this cycle
//   pc_write     PC load enable; pc_src selects 0=PC+4, 1=branch, 2=jump
//   *_write      pipeline latch enables
//   *_flush      latch loads a NOP / bubble
//   mem_err      sticky memory-timeout flag
//   stall_cnt    RUN/MEM_WAIT cycles with pc_write=0 (saturating)
//   flush_cnt    redirects taken (saturating)
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
   parameter int CNT_W    = 16,
   parameter int WAIT_MAX = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             ex_MemRead,
   input  logic [4:0]       ex_rt,
   input  logic             mem_branch,
   input  logic             mem_zero,
   input  logic             mem_jump,
   input  logic             mem_access,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             ifid_write,
   output logic             idex_write,
   output logic             exmem_write,
   output logic             memwb_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2,
      ERROR    = 2'd3
   } state_t;

   localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

   state_t           state_reg, state_next;
   logic [7:0]       timer_reg, timer_next;
   logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
   logic             mem_err_reg;

   logic redirect;
   logic load_use;
   logic run_ctrl;     // apply the normal redirect / load-use / advance decision
   logic stall_inc;
   logic flush_inc;
   logic err_set;

   assign redirect = (mem_branch & mem_zero) | mem_jump;
   // r0 is hard-wired zero, so a load targeting it never creates a hazard
   assign load_use = ex_MemRead & (ex_rt != 5'd0) &
                     ((ex_rt == id_rs) | (ex_rt == id_rt));

   // ---------------- state / counter registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= BOOT;
         timer_reg     <= '0;
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
         mem_err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         timer_reg <= timer_next;
         if (stall_inc && (stall_cnt_reg != {CNT_W{1'b1}}))
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
         if (flush_inc && (flush_cnt_reg != {CNT_W{1'b1}}))
            flush_cnt_reg <= flush_cnt_reg + 1'b1;
         if (err_set)
            mem_err_reg <= 1'b1;
      end
   end

   // ---------------- next state and outputs ----------------
   always_comb begin
      state_next  = state_reg;
      timer_next  = timer_reg;
      run_ctrl    = 1'b0;
      err_set     = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 2'd0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;

      case (state_reg)
         BOOT: begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            timer_next  = '0;
            state_next  = RUN;
         end
         RUN: begin
            // Memory stall outranks everything: the whole pipe freezes and
            // the redirect/hazard is re-evaluated once memory completes.
            if (mem_access && !dmem_ready) begin
               timer_next = 8'd1;
               state_next = MEM_WAIT;
            end else begin
               run_ctrl = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (dmem_ready) begin
               run_ctrl   = 1'b1;
               timer_next = '0;
               state_next = RUN;
            end else if (timer_reg < WAIT_LIMIT) begin
               timer_next = timer_reg + 8'd1;
            end else begin
               err_set    = 1'b1;
               state_next = ERROR;
            end
         end
         default: begin
            // ERROR: frozen, no flush; only reset leaves this state
         end
      endcase

      if (run_ctrl) begin
         if (redirect) begin
            // The instruction in ID is squashed, so any load-use is moot.
            pc_src      = mem_jump ? 2'd2 : 2'd1;
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            idex_write  = 1'b1;
            exmem_write = 1'b1;
            memwb_write = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
         end else if (load_use) begin
            // Hold PC and IF/ID, push one bubble into ID/EX.
            idex_write  = 1'b1;
            exmem_write = 1'b1;
            memwb_write = 1'b1;
            idex_flush  = 1'b1;
         end else begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            idex_write  = 1'b1;
            exmem_write = 1'b1;
            memwb_write = 1'b1;
         end
      end

      stall_inc = ((state_reg == RUN) || (state_reg == MEM_WAIT)) && !pc_write;
      flush_inc = run_ctrl && redirect;
   end

   assign stall_cnt = stall_cnt_reg;
   assign flush_cnt = flush_cnt_reg;
   assign mem_err   = mem_err_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
   logic       ex_MemRead = 0, mem_branch = 0, mem_zero = 0, mem_jump = 0;
   logic       mem_access = 0, dmem_ready = 0;

   logic        pc_write, ifid_write, idex_write, exmem_write, memwb_write;
   logic        ifid_flush, idex_flush, exmem_flush, mem_err;
   logic [1:0]  pc_src;
   logic [15:0] stall_cnt, flush_cnt;

   logic        s_pc_write, s_ifid_write, s_idex_write, s_exmem_write, s_memwb_write;
   logic        s_ifid_flush, s_idex_flush, s_exmem_flush, s_mem_err;
   logic [1:0]  s_pc_src;
   logic [3:0]  s_stall_cnt, s_flush_cnt;

   always #5 clk = ~clk;

   pipeline_ctrl dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .mem_branch(mem_branch),
      .mem_zero(mem_zero), .mem_jump(mem_jump), .mem_access(mem_access),
      .dmem_ready(dmem_ready), .pc_write(pc_write), .pc_src(pc_src),
      .ifid_write(ifid_write), .idex_write(idex_write), .exmem_write(exmem_write),
      .memwb_write(memwb_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .mem_err(mem_err), .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt)
   );

   pipeline_ctrl #(.CNT_W(4), .WAIT_MAX(15)) dut_sat (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .mem_branch(mem_branch),
      .mem_zero(mem_zero), .mem_jump(mem_jump), .mem_access(mem_access),
      .dmem_ready(dmem_ready), .pc_write(s_pc_write), .pc_src(s_pc_src),
      .ifid_write(s_ifid_write), .idex_write(s_idex_write), .exmem_write(s_exmem_write),
      .memwb_write(s_memwb_write), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
      .exmem_flush(s_exmem_flush), .mem_err(s_mem_err), .stall_cnt(s_stall_cnt),
      .flush_cnt(s_flush_cnt)
   );

   // ctrl = {pc_write, pc_src[1:0], ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f, exmem_f}
   localparam logic [9:0] BOOT_V = 10'b0_00_0000_111;
   localparam logic [9:0] RUN_V  = 10'b1_00_1111_000;
   localparam logic [9:0] FROZ   = 10'b0_00_0000_000;
   localparam logic [9:0] LU     = 10'b0_00_0111_010;
   localparam logic [9:0] BR     = 10'b1_01_1111_111;
   localparam logic [9:0] JMP    = 10'b1_10_1111_111;

   typedef struct {
      string      name;
      logic [9:0] ctrl;
      logic       err;
      int         s;
      int         f;
      int         sat_s;
      int         sat_f;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic ld, input logic [4:0] ert, input logic [4:0] irs,
                         input logic [4:0] irt, input logic br, input logic z,
                         input logic jmp, input logic acc, input logic rdy);
      ex_MemRead = ld; ex_rt = ert; id_rs = irs; id_rt = irt;
      mem_branch = br; mem_zero = z; mem_jump = jmp; mem_access = acc; dmem_ready = rdy;
   endtask

   task automatic idle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Push one cycle's expected outputs (counters as seen mid-cycle), then advance.
   task automatic vec(input string name, input logic [9:0] ctrl, input logic err,
                      input int s, input int f);
      exp_t e;
      e.name  = name;
      e.ctrl  = ctrl;
      e.err   = err;
      e.s     = s;
      e.f     = f;
      e.sat_s = (s > 15) ? 15 : s;
      e.sat_f = (f > 15) ? 15 : f;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      fork
         begin : stimulus
            idle();
            @(posedge clk);
            #1;
            // 1. reset and boot
            vec("reset0", BOOT_V, 0, 0, 0);
            vec("reset1", BOOT_V, 0, 0, 0);
            rst = 1'b1;
            vec("boot", BOOT_V, 0, 0, 0);
            vec("run", RUN_V, 0, 0, 0);
            // 2. load-use hazards
            set_in(1, 8, 8, 0, 0, 0, 0, 0, 0);   vec("lu_rs", LU, 0, 0, 0);
            idle();                              vec("after_lu", RUN_V, 0, 1, 0);
            set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);   vec("lu_r0", RUN_V, 0, 1, 0);
            set_in(1, 8, 3, 8, 0, 0, 0, 0, 0);   vec("lu_rt", LU, 0, 1, 0);
            idle();                              vec("after_lu2", RUN_V, 0, 2, 0);
            set_in(1, 8, 9, 10, 0, 0, 0, 0, 0);  vec("lu_nomatch", RUN_V, 0, 2, 0);
            set_in(0, 8, 8, 0, 0, 0, 0, 0, 0);   vec("lu_noload", RUN_V, 0, 2, 0);
            // 3. redirects
            set_in(0, 0, 0, 0, 1, 1, 0, 0, 0);   vec("branch", BR, 0, 2, 0);
            idle();                              vec("after_br", RUN_V, 0, 2, 1);
            set_in(0, 0, 0, 0, 1, 0, 0, 0, 0);   vec("br_nottaken", RUN_V, 0, 2, 1);
            set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);   vec("jump", JMP, 0, 2, 1);
            set_in(0, 0, 0, 0, 1, 1, 1, 0, 0);   vec("jump_wins", JMP, 0, 2, 2);
            set_in(1, 8, 8, 0, 1, 1, 0, 0, 0);   vec("br_plus_lu", BR, 0, 2, 3);
            idle();                              vec("after_brlu", RUN_V, 0, 2, 4);
            // 4. memory wait, 3 frozen cycles then advance
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);   vec("mw1", FROZ, 0, 2, 4);
                                                 vec("mw2", FROZ, 0, 3, 4);
                                                 vec("mw3", FROZ, 0, 4, 4);
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);   vec("mw_ready", RUN_V, 0, 5, 4);
            idle();                              vec("after_mw", RUN_V, 0, 5, 4);
            // memory wait ending in a redirect, then in a load-use
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);   vec("mwj1", FROZ, 0, 5, 4);
            set_in(0, 0, 0, 0, 0, 0, 1, 1, 1);   vec("mwj_jump", JMP, 0, 6, 4);
            idle();                              vec("after_mwj", RUN_V, 0, 6, 5);
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);   vec("mwl1", FROZ, 0, 6, 5);
            set_in(1, 8, 8, 0, 0, 0, 0, 1, 1);   vec("mwl_lu", LU, 0, 7, 5);
            idle();                              vec("after_mwl", RUN_V, 0, 8, 5);
            // 5. timeout: 16 frozen cycles, then ERROR
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
            for (int i = 0; i < 16; i++)
               vec($sformatf("to_wait%0d", i), FROZ, 0, 8 + i, 5);
            vec("error", FROZ, 1, 24, 5);
            set_in(1, 8, 8, 0, 0, 0, 1, 1, 1);   vec("error_hold", FROZ, 1, 24, 5);
            vec("error_hold2", FROZ, 1, 24, 5);
            rst = 1'b0;                          vec("rst_err", BOOT_V, 0, 0, 0);
            rst = 1'b1; idle();                  vec("boot2", BOOT_V, 0, 0, 0);
                                                 vec("run2", RUN_V, 0, 0, 0);
            // reset in the middle of a memory stall
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);   vec("ms1", FROZ, 0, 0, 0);
                                                 vec("ms2", FROZ, 0, 1, 0);
            rst = 1'b0;                          vec("rst_stall", BOOT_V, 0, 0, 0);
            rst = 1'b1; idle();                  vec("boot3", BOOT_V, 0, 0, 0);
                                                 vec("run3", RUN_V, 0, 0, 0);
            // 6. saturation on the 4-bit instance
            for (int i = 0; i < 20; i++) begin
               set_in(1, 5, 5, 0, 0, 0, 0, 0, 0);
               vec($sformatf("sat_lu%0d", i), LU, 0, i, 0);
               idle();
               vec($sformatf("sat_idle%0d", i), RUN_V, 0, i + 1, 0);
            end
            set_in(0, 0, 0, 0, 1, 1, 0, 0, 0);
            for (int i = 0; i < 20; i++)
               vec($sformatf("sat_br%0d", i), BR, 0, 20, i);
            idle();
            vec("final", RUN_V, 0, 20, 20);
         end
         begin : monitor
            forever begin
               @(negedge clk);
               if (q.size() > 0) begin
                  mon_e = q.pop_front();
                  chk({mon_e.name, " ctrl"}, 32'({pc_write, pc_src, ifid_write, idex_write,
                      exmem_write, memwb_write, ifid_flush, idex_flush, exmem_flush}),
                      32'(mon_e.ctrl));
                  chk({mon_e.name, " mem_err"}, 32'(mem_err), 32'(mon_e.err));
                  chk({mon_e.name, " stall_cnt"}, 32'(stall_cnt), mon_e.s);
                  chk({mon_e.name, " flush_cnt"}, 32'(flush_cnt), mon_e.f);
                  chk({mon_e.name, " sat_stall_cnt"}, 32'(s_stall_cnt), mon_e.sat_s);
                  chk({mon_e.name, " sat_flush_cnt"}, 32'(s_flush_cnt), mon_e.sat_f);
                  $display("txn %-12s ctrl=%b err=%0d stall=%0d flush=%0d sat=%0d/%0d",
                           mon_e.name, {pc_write, pc_src, ifid_write, idex_write,
                           exmem_write, memwb_write, ifid_flush, idex_flush, exmem_flush},
                           mem_err, stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt);
               end
            end
         end
      join_any
      disable fork;
      chk("scoreboard_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
